map_write_arbiter: RTL
======================

Name: map_write_arbiter

Overview:
- Shares the single write port of the tile map memory between NUM_REQ requesters: P1 bomb logic, P2 bomb logic and explosion/block-destroy logic.
- Each requester pushes writes into its own small FIFO.
- A round-robin scheduler drains one write per cycle onto a registered write bus.
- That bus drives both the map RAM and power_up's we_in/write_addr_in/write_data_in.

Parameters:
- NUM_ROW, 11, map rows
- NUM_COL, 19, map columns
- MAP_MEM_WIDTH, 2, bits per map tile
- NUM_REQ, 3, number of requesters (index 0 = P1 bomb, 1 = P2 bomb, 2 = explosion)
- FIFO_DEPTH, 4, entries per requester FIFO (power of two, ≥2)
- Derived localparams: DEPTH = NUM_ROW*NUM_COL; ADDR_WIDTH = $clog2(DEPTH), which is 8 at defaults

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- game_over  in  1  level; flushes and blocks all traffic while high
- req_valid  in  NUM_REQ  per-requester write valid
- req_ready  out  NUM_REQ  per-requester ready; accept when valid&ready
- req_addr  in  NUM_REQ*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NUM_REQ*MAP_MEM_WIDTH  requester i at [i*MAP_MEM_WIDTH +: MAP_MEM_WIDTH]
- we_out  out  1  registered map write enable (one-cycle pulse per write)
- write_addr_out  out  ADDR_WIDTH  registered write address
- write_data_out  out  MAP_MEM_WIDTH  registered write data
- grant_id  out  $clog2(NUM_REQ)  requester index of the current we_out
- addr_err  out  1  one-cycle pulse: an out-of-range write was accepted and dropped

Behaviour:
- Reset (rst==0 at a clk edge):
  - all FIFOs emptied;
  - we_out=0, write_addr_out=0, write_data_out=0, grant_id=0, addr_err=0;
  - round-robin pointer=0;
  - req_ready=0 while rst is low.
- Accept:
  - req_ready[i] = rst && !game_over && !full[i]. It is combinational and based on pre-edge occupancy.
  - A push to a full FIFO cannot occur, even if that FIFO pops in the same cycle.
  - Simultaneous push and pop on a non-full FIFO is legal; occupancy is unchanged.
- Range check:
  - An accepted beat with addr ≥ DEPTH is not stored.
  - addr_err pulses high on the following cycle.
  - If several requesters are out of range in the same cycle, only a single addr_err pulse is produced.
- FIFO:
  - per-requester, first-in first-out, full/empty flags;
  - read/write pointers wrap modulo FIFO_DEPTH;
  - count is 0..FIFO_DEPTH.
- Scheduler (one grant per cycle):
  - Search starts at the pointer and moves upward, modulo NUM_REQ.
  - The first non-empty FIFO is granted and popped.
  - On the next edge: we_out=1, write_addr_out/write_data_out = the popped entry, grant_id = index.
  - The pointer becomes (granted index + 1) mod NUM_REQ.
  - If no FIFO is non-empty: we_out=0, the pointer holds, and addr/data/grant_id hold their last values.
- Latency:
  - Accept at edge N gives a grant in cycle N+1 and we_out high in cycle N+2 (minimum 2 cycles).
  - Throughput is 1 write/cycle in aggregate.
- Fairness: with all FIFOs non-empty, grants rotate 0,1,2,0,… and no requester waits more than NUM_REQ-1 grants.
- Same-address writes from different requesters are serialized in grant order; the later grant wins in memory. No merging.
- game_over high at an edge:
  - all FIFOs flushed (counts to 0);
  - we_out=0 from the next cycle;
  - any grant pending in that cycle is discarded;
  - the pointer is preserved;
  - req_ready=0 while game_over stays high.
- State outline per cycle: IDLE (all empty, we_out=0) ↔ DRAIN (≥1 non-empty). The scheduler itself is a pointer plus a priority search; no other states.

Decomposition:
- Shared package bomberman_map_pkg:
  - NUM_ROW, NUM_COL, MAP_MEM_WIDTH, DEPTH, ADDR_WIDTH;
  - tile encodings (free, hard wall, soft block, bomb);
  - requester index constants REQ_P1_BOMB=0, REQ_P2_BOMB=1, REQ_EXPLODE=2.
- Sub-module map_wr_fifo (params WIDTH, DEPTH):
  - push/pop/flush;
  - full/empty/count;
  - instantiated NUM_REQ times via generate.

Test Plan:
- Reset then idle: rst low 3 cycles, then high with no valids -> we_out=0, grant_id=0, req_ready=3'b111, addr_err=0.
- Single write: req 0 writes addr 20, data 2'b11 at edge N -> we_out=1 exactly in cycle N+2 with write_addr_out=20, write_data_out=3; we_out=0 in cycle N+3.
- Round-robin: all three requesters push 2 entries each (addrs 20/21, 40/41, 60/61) in one burst -> we_out high 6 consecutive cycles with grant_id 0,1,2,0,1,2 and addrs 20,40,60,21,41,61.
- Backpressure: requester 1 pushes 5 back-to-back beats while requesters 0 and 2 keep their FIFOs non-empty -> req_ready[1]=0 when count hits 4; no beat is lost and all 5 addresses appear in order.
- Range error: req 2 writes addr 209 -> addr_err pulses 1 cycle; no we_out for it; a following valid write to addr 39 still emerges 2 cycles after its accept.
- game_over flush: 3 entries queued, game_over high 1 cycle -> we_out=0 from the next cycle, all counts 0, req_ready=0 during game_over; a new write after deassert emerges normally.

Source files
------------

// File: rtl/bomberman_map_pkg.sv
// Shared map definitions for the tile-map write path.
// Holds map geometry, tile encodings, requester indices and the
// arbiter FSM state type used by map_write_arbiter.
package bomberman_map_pkg;

    localparam int NUM_ROW       = 11;
    localparam int NUM_COL       = 19;
    localparam int MAP_MEM_WIDTH = 2;
    localparam int DEPTH         = NUM_ROW * NUM_COL;
    localparam int ADDR_WIDTH    = $clog2(DEPTH);

    localparam int NUM_REQ    = 3;
    localparam int FIFO_DEPTH = 4;

    localparam int REQ_P1_BOMB = 0;
    localparam int REQ_P2_BOMB = 1;
    localparam int REQ_EXPLODE = 2;

    typedef enum logic [MAP_MEM_WIDTH-1:0] {
        TILE_FREE = 2'd0,
        TILE_HARD = 2'd1,
        TILE_SOFT = 2'd2,
        TILE_BOMB = 2'd3
    } tile_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_DRAIN = 1'b1
    } arb_state_t;

endpackage

// File: rtl/map_write_arbiter_if.sv
// Requester handshake plus registered map write bus.
//   req_valid/req_addr/req_data : requester -> arbiter (packed per requester)
//   req_ready                   : arbiter -> requester
//   we_out/write_addr_out/write_data_out/grant_id/addr_err : arbiter -> map RAM, power_up
// master = requester/consumer side, slave = arbiter side.
interface map_write_arbiter_if
    import bomberman_map_pkg::*;
#(
    parameter int NUM_REQ       = bomberman_map_pkg::NUM_REQ,
    parameter int ADDR_WIDTH    = bomberman_map_pkg::ADDR_WIDTH,
    parameter int MAP_MEM_WIDTH = bomberman_map_pkg::MAP_MEM_WIDTH
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr;
    logic [NUM_REQ*MAP_MEM_WIDTH-1:0] req_data;
    logic                             we_out;
    logic [ADDR_WIDTH-1:0]            write_addr_out;
    logic [MAP_MEM_WIDTH-1:0]         write_data_out;
    logic [GID_W-1:0]                 grant_id;
    logic                             addr_err;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, we_out, write_addr_out, write_data_out, grant_id, addr_err
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, we_out, write_addr_out, write_data_out, grant_id, addr_err
    );

endinterface

// File: rtl/map_wr_fifo.sv
// Small per-requester write FIFO.
//   clk, rst (sync, active low), flush : clear all entries
//   push/din  : write when not full (a full FIFO never accepts, even on a pop)
//   pop/dout  : dout is the head entry, consumed on pop when not empty
//   full, empty, count (0..DEPTH)
module map_wr_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/map_write_arbiter.sv
// Shares the single tile-map write port between NUM_REQ requesters
// (P1 bomb, P2 bomb, explosion). Each requester has its own FIFO; a
// round-robin scheduler drains one entry per cycle onto a registered
// write bus feeding the map RAM and power_up.
//   clk, rst (sync, active low), game_over (flush + block while high)
//   bus : map_write_arbiter_if.slave (requester handshake + write bus)
//
// state     | meaning
// ----------+----------------------------------------------
// ARB_IDLE  | every FIFO empty, no grant issued
// ARB_DRAIN | at least one FIFO holds an entry, grant issued
module map_write_arbiter
    import bomberman_map_pkg::*;
#(
    parameter int NUM_ROW       = bomberman_map_pkg::NUM_ROW,
    parameter int NUM_COL       = bomberman_map_pkg::NUM_COL,
    parameter int MAP_MEM_WIDTH = bomberman_map_pkg::MAP_MEM_WIDTH,
    parameter int NUM_REQ       = bomberman_map_pkg::NUM_REQ,
    parameter int FIFO_DEPTH    = bomberman_map_pkg::FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         game_over,
    map_write_arbiter_if.slave bus
);
    localparam int DEPTH      = NUM_ROW * NUM_COL;
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int GID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W    = ADDR_WIDTH + MAP_MEM_WIDTH;

    arb_state_t state_q, state_d;

    logic [NUM_REQ-1:0] accept, in_range, push, pop, full, empty, still_busy;
    logic [ENTRY_W-1:0] fifo_dout [NUM_REQ];
    logic [CNT_W-1:0]   fifo_cnt  [NUM_REQ];

    logic               grant_valid;
    logic [GID_W-1:0]   grant_idx;
    logic [ENTRY_W-1:0] grant_entry;
    logic               issue;
    logic               range_err;

    logic [GID_W-1:0]         ptr_q;
    logic                     we_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [MAP_MEM_WIDTH-1:0] data_q;
    logic [GID_W-1:0]         gid_q;
    logic                     addr_err_q;

    assign bus.req_ready      = (rst && !game_over) ? ~full : '0;
    assign accept             = bus.req_valid & bus.req_ready;
    assign push               = accept & in_range;
    assign range_err          = |(accept & ~in_range);

    assign bus.we_out         = we_q;
    assign bus.write_addr_out = addr_q;
    assign bus.write_data_out = data_q;
    assign bus.grant_id       = gid_q;
    assign bus.addr_err       = addr_err_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        logic [ADDR_WIDTH-1:0]    addr_i;
        logic [MAP_MEM_WIDTH-1:0] data_i;

        assign addr_i      = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_i      = bus.req_data[i*MAP_MEM_WIDTH +: MAP_MEM_WIDTH];
        // Widened compare so a DEPTH that is an exact power of two still works.
        assign in_range[i] = ({1'b0, addr_i} < (ADDR_WIDTH+1)'(DEPTH));

        // FIFO i still holds something after this edge, ignoring game_over.
        assign still_busy[i] = push[i] || (fifo_cnt[i] > CNT_W'(1)) ||
                               (!empty[i] && !(grant_valid && grant_idx == GID_W'(i)));

        map_wr_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (game_over),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   ({addr_i, data_i}),
            .dout  (fifo_dout[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .count (fifo_cnt[i])
        );
    end

    // Priority search starting at the round-robin pointer, wrapping upward.
    always_comb begin
        logic [GID_W:0]   sum;
        logic [GID_W-1:0] idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_entry = '0;
        sum         = '0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (GID_W+1)'(k);
            if (sum >= (GID_W+1)'(NUM_REQ)) begin
                sum = sum - (GID_W+1)'(NUM_REQ);
            end
            idx = sum[GID_W-1:0];
            if (!grant_valid && !empty[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == GID_W'(i)) begin
                grant_entry = fifo_dout[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A grant seen in the same cycle as game_over is dropped with the flush.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        pop     = '0;
        case (state_q)
            ARB_IDLE: begin
                if (!game_over && |push) state_d = ARB_DRAIN;
            end
            ARB_DRAIN: begin
                issue = grant_valid && !game_over;
                if (game_over || !(|still_busy)) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
        for (int i = 0; i < NUM_REQ; i++) begin
            pop[i] = issue && (grant_idx == GID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            gid_q      <= '0;
            addr_err_q <= 1'b0;
        end else begin
            we_q       <= issue;
            addr_err_q <= range_err;
            if (issue) begin
                addr_q <= grant_entry[ENTRY_W-1:MAP_MEM_WIDTH];
                data_q <= grant_entry[MAP_MEM_WIDTH-1:0];
                gid_q  <= grant_idx;
                ptr_q  <= (grant_idx == GID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

endmodule
